// File: rtl/word_store_serializer.sv
// Store-path serializer: writes a 16-bit word to a byte-wide memory.
// The low byte goes to the base address first, then the high byte to base+1.
//
// Ports:
//   Clock     in   rising-edge system clock
//   Reset     in   asynchronous active-low reset
//   Start     in   request strobe, ignored while Busy
//   Word      in   16-bit data, captured when Start is accepted
//   Address   in   base address, captured when Start is accepted
//   Busy      out  high while a transfer is in progress
//   Done      out  one-cycle completion pulse
//   MemAddr   out  memory address (holds its last value when idle)
//   MemData   out  memory write data (holds its last value when idle)
//   MemWrite  out  active-high memory write enable
module word_store_serializer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [15:0]           Word,
  input  logic [ADDR_WIDTH-1:0] Address,
  output logic                  Busy,
  output logic                  Done,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [7:0]            MemData,
  output logic                  MemWrite
);

  localparam int CW = (WAIT_CYCLES > 0) ?
    $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WR_LO,
    WR_HI
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [15:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [7:0]            mdata_q, mdata_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    we_d    = we_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          word_d  = Word;
          addr_d  = Address;
          state_d = WR_LO;
          cnt_d   = '0;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          maddr_d = Address;
          mdata_d = Word[7:0];
        end
      end
      WR_LO: begin
        if (cnt_q != CMAX) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          state_d = WR_HI;
          cnt_d   = '0;
          // wraps modulo 2^ADDR_WIDTH
          maddr_d = addr_q + ADDR_WIDTH'(1);
          mdata_d = word_q[15:8];
        end
      end
      WR_HI: begin
        if (cnt_q != CMAX) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign MemAddr  = maddr_q;
  assign MemData  = mdata_q;
  assign MemWrite = we_q;

endmodule

// File: doc/word_store_serializer.md
# word_store_serializer

Store-path serializer for the byte-wide memory bus: it accepts a 16-bit word and a base address, then writes the word to the 8-bit memory as two sequential byte writes. The low byte goes to the base address and the high byte to base+1. This is the write-side counterpart of the instruction register's two-step byte load, which loads the low half first and then the high half. It sits between the register file/ALU output and the memory write port, and is started by the control unit.

## Interface
- `ADDR_WIDTH`, 16, width of base and memory address.
- `WAIT_CYCLES`, 0, extra cycles each byte write is held on the bus. Each byte occupies WAIT_CYCLES+1 cycles.

- `Clock`  in  1  system clock, rising-edge active.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request strobe, sampled on rising edge of Clock.
- `Word`  in  16  data to store, captured when a Start is accepted.
- `Address`  in  ADDR_WIDTH  base address, captured when a Start is accepted.
- `Busy`  out  1  high while a transfer is in progress.
- `Done`  out  1  one-cycle completion pulse.
- `MemAddr`  out  ADDR_WIDTH  memory address.
- `MemData`  out  8  memory write data.
- `MemWrite`  out  1  memory write enable, active-high.

## Operation
- States: IDLE, WR_LO, WR_HI. One cycle counter `cnt` runs 0..WAIT_CYCLES.
- All outputs are registered.
- IDLE:
  - Start=1 captures Word into `word_q` and Address into `addr_q`.
  - Then: state←WR_LO, cnt←0, Busy←1, MemWrite←1, MemAddr←Address, MemData←Word[7:0].
  - Start=0: no change.
- WR_LO:
  - cnt≠WAIT_CYCLES: cnt increments and bus outputs hold.
  - cnt=WAIT_CYCLES: state←WR_HI, cnt←0, MemAddr←addr_q+1, MemData←word_q[15:8].
- WR_HI:
  - cnt≠WAIT_CYCLES: cnt increments and bus outputs hold.
  - cnt=WAIT_CYCLES: state←IDLE, Busy←0, MemWrite←0, Done←1.
- Done is cleared on every edge where it is not being set, so it is a single-cycle pulse.
- Address arithmetic: addr_q+1 is computed modulo 2^ADDR_WIDTH, so the all-ones base address wraps to 0.
- Start while Busy=1 is ignored. There is no queueing and the captured word and address are unaffected.
- Word and Address may change freely after acceptance.
- Start sampled in the cycle where Done=1 is accepted, because the block is already in IDLE. Done then falls on that same edge.
- MemAddr and MemData hold their last values in IDLE. Only MemWrite qualifies the bus.

## Timing
- Reset (Reset=0, asynchronous):
  - state=IDLE, cnt=0.
  - Busy=0, Done=0, MemWrite=0, MemAddr=0, MemData=0.
  - word_q=0, addr_q=0.
- Reset mid-transfer aborts immediately. MemWrite drops without waiting for Clock and no Done is issued.
- Start accepted at edge k:
  - MemWrite=1 with the low byte from edge k to edge k+W+1, where W=WAIT_CYCLES.
  - High byte from edge k+W+1 to edge k+2W+2.
  - Done=1 and Busy=0 for one cycle starting at edge k+2W+2.
- Write occupancy is 2(W+1) cycles.
- Minimum Start-to-Start spacing for back-to-back transfers is 2W+3 cycles. This leaves one MemWrite=0 cycle between transfers.
- No combinational path from inputs to outputs.

## Test plan
- **Reset values:** hold Reset=0 with random inputs. Required response: all outputs 0. Release reset with Start=0: outputs stay 0.
- **Basic store, W=0:** Start with Word=16'hA55A, Address=16'h0040. Required response:
  - Edge k+1 write: MemAddr=0040, MemData=5A.
  - Edge k+2 write: MemAddr=0041, MemData=A5.
  - Done pulse in the following cycle.
- **Wait states, W=2:** Word=16'h1234, Address=16'h0100. Required response:
  - Byte 34 at address 0100 is held for 3 cycles.
  - Byte 12 at address 0101 is held for 3 cycles.
  - Done occurs at edge k+6.
- **Address wrap:** Address=16'hFFFF, Word=16'hBEEF. Required response: EF written at FFFF, then BE written at 0000.
- **Ignored and back-to-back Start:** re-assert Start with Word=16'h9999 during a transfer of 16'h00FF. Required response:
  - Bus still shows FF then 00 and no extra write occurs.
  - Start asserted with Done high is accepted. The next write is seen exactly one idle cycle later.
- **Reset mid-operation:** pull Reset low during WR_HI. Required response:
  - MemWrite=0 immediately and no Done.
  - After release, a new Start works normally.
